dac_wave_gen: RTL and testbench

DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

---
 rtl/dac_wave_gen.sv | 98 +++++++++
 tb/tb_dac_wave_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: paced phase accumulator that drives a triangle-wave code to a DAC
// over a valid/ready handshake. A new sample is dropped, and the overrun flag set, while the previous code is still pending.
`default_nettype none

module dac_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int DAC_W   = 12
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               swiptAlive,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [7:0]         div,
  input  logic               dac_ready,
  output logic [DAC_W-1:0]   DAC,
  output logic               dac_valid,
  output logic               sign,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [DAC_W-1:0] MID_CODE = {1'b1, {(DAC_W-1){1'b0}}};

  state_t             state;
  logic [7:0]         cnt;
  logic [PHASE_W-1:0] phase;

  logic               tick;
  logic               xfer;
  logic [PHASE_W-1:0] phase_nxt;
  logic [DAC_W-1:0]   code_nxt;

  // Triangle fold: the phase MSB selects the rising or the mirrored falling half.
  always_comb begin
    tick      = (cnt == div);
    xfer      = dac_valid & dac_ready;
    phase_nxt = phase + ftw;
    code_nxt  = phase_nxt[PHASE_W-2 -: DAC_W];
    if (phase_nxt[PHASE_W-1])
      code_nxt = ~phase_nxt[PHASE_W-2 -: DAC_W];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase     <= '0;
      DAC       <= MID_CODE;
      dac_valid <= 1'b0;
      sign      <= 1'b0;
      overrun   <= 1'b0;
    end else if (!swiptAlive) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase     <= '0;
      DAC       <= MID_CODE;
      dac_valid <= 1'b0;
      sign      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_RUN;
          cnt   <= '0;
        end
        S_RUN, S_HOLD: begin
          cnt <= tick ? 8'd0 : cnt + 8'd1;
          if (tick)
            phase <= phase_nxt;
          // A code loads when nothing is pending or the pending one leaves this edge.
          if (tick && (state == S_RUN || xfer)) begin
            DAC       <= code_nxt;
            sign      <= ~code_nxt[DAC_W-1];
            dac_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (xfer) begin
            dac_valid <= 1'b0;
            state     <= S_RUN;
          end else if (tick) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          dac_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: table vectors, directed corner sequences and a randomized
// comparison against an arithmetic reference model of the waveform generator.
`default_nettype none

module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b0;
  logic [15:0] ftw = '0;
  logic [7:0]  div = '0;
  logic        dac_ready = 1'b0;
  logic [11:0] DAC;
  logic        dac_valid, sign, overrun;

  int tests = 0;
  int failed = 0;

  dac_wave_gen #(.PHASE_W(16), .DAC_W(12)) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .ftw(ftw), .div(div),
    .dac_ready(dac_ready), .DAC(DAC), .dac_valid(dac_valid), .sign(sign),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ftw;
    logic [7:0]  div;
    logic        ready;
    int          n;
    logic [11:0] dac;
    logic        valid;
    logic        sgn;
    logic        ovr;
  } vec_t;

  vec_t vt[13];

  // Reference model state: spec-level quantities only.
  bit m_active;
  int m_elapsed, m_phase, m_dac;
  bit m_pend, m_sgn, m_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [11:0] d, input logic v,
                         input logic s, input logic o);
    chk({nm, ".dac"}, 32'(DAC), 32'(d));
    chk({nm, ".valid"}, 32'(dac_valid), 32'(v));
    chk({nm, ".sign"}, 32'(sign), 32'(s));
    chk({nm, ".ovr"}, 32'(overrun), 32'(o));
  endtask

  task automatic step(input logic sw, input logic rdy);
    @(negedge clk);
    swiptAlive = sw;
    dac_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic int tri_code(input int p);
    int lin;
    lin = (p % 32768) / 8;
    return (p >= 32768) ? 4095 - lin : lin;
  endfunction

  task automatic model_edge(input bit sw, input bit rdy, input int f, input int d);
    bit tk, xf;
    if (!sw) begin
      m_active = 0; m_elapsed = 0; m_phase = 0; m_dac = 2048;
      m_pend = 0; m_sgn = 0; m_ovr = 0;
    end else if (!m_active) begin
      m_active = 1; m_elapsed = 0;
    end else begin
      tk = (m_elapsed == d);
      m_elapsed = tk ? 0 : (m_elapsed + 1) % 256;
      xf = m_pend && rdy;
      if (tk) m_phase = (m_phase + f) % 65536;
      if (tk && (!m_pend || xf)) begin
        m_dac = tri_code(m_phase);
        m_sgn = (m_dac < 2048);
        m_pend = 1;
      end else if (xf) begin
        m_pend = 0;
      end else if (tk) begin
        m_ovr = 1;
      end
    end
  endtask

  initial begin
    vt[0]  = '{16'h0100, 8'd0,   1'b1, 1,   12'h020, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{16'h0100, 8'd0,   1'b1, 3,   12'h060, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{16'h8000, 8'd0,   1'b1, 1,   12'hFFF, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 8'd0,   1'b1, 2,   12'h000, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{16'h0100, 8'd3,   1'b1, 3,   12'h800, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{16'h0100, 8'd3,   1'b1, 4,   12'h020, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{16'h0100, 8'd3,   1'b1, 5,   12'h020, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{16'h0100, 8'd0,   1'b0, 2,   12'h020, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{16'hC000, 8'd1,   1'b1, 2,   12'h7FF, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{16'h4000, 8'd0,   1'b1, 1,   12'h800, 1'b1, 1'b0, 1'b0};
    vt[10] = '{16'h0000, 8'd0,   1'b1, 3,   12'h000, 1'b1, 1'b1, 1'b0};
    vt[11] = '{16'h0100, 8'd255, 1'b1, 255, 12'h800, 1'b0, 1'b0, 1'b0};
    vt[12] = '{16'h0100, 8'd255, 1'b1, 256, 12'h020, 1'b1, 1'b1, 1'b0};

    #12;
    chk_all("reset", 12'h800, 1'b0, 1'b0, 1'b0);
    nrst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      ftw = vt[i].ftw;
      div = vt[i].div;
      step(1'b0, vt[i].ready);
      repeat (vt[i].n + 1) step(1'b1, vt[i].ready);
      chk_all($sformatf("vec%0d", i), vt[i].dac, vt[i].valid, vt[i].sgn, vt[i].ovr);
    end

    // Asynchronous reset while holding an overrun code.
    ftw = 16'h0100; div = 8'd0;
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    chk_all("pre_rst", 12'h020, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_all("async_rst", 12'h800, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    // Backpressure over three ticks, then release.
    ftw = 16'h0100; div = 8'd1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b0);
    chk_all("bp_hold", 12'h020, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("bp_xfer.valid", 32'(dac_valid), 32'd0);
    step(1'b1, 1'b1);
    chk_all("bp_next", 12'h080, 1'b1, 1'b1, 1'b1);

    // Abort from HOLD, then restart from phase zero.
    step(1'b0, 1'b0);
    chk_all("abort", 12'h800, 1'b0, 1'b0, 1'b0);
    ftw = 16'h0100; div = 8'd0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_all("restart", 12'h020, 1'b1, 1'b1, 1'b0);

    // Full ramp period, then randomized traffic, both against the model.
    step(1'b0, 1'b0);
    model_edge(1'b0, 1'b0, 0, 0);
    for (int c = 0; c < 3600; c++) begin
      bit sw, rdy;
      @(negedge clk);
      if (c < 520) begin
        sw = 1'b1; rdy = 1'b1; ftw = 16'h0100; div = 8'd0;
      end else begin
        sw  = ($urandom_range(0, 99) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 49) == 0) ftw = 16'($urandom);
        if ($urandom_range(0, 99) == 0) div = 8'($urandom_range(0, 4));
      end
      swiptAlive = sw;
      dac_ready  = rdy;
      model_edge(sw, rdy, int'(ftw), int'(div));
      @(posedge clk);
      #1;
      if (DAC !== 12'(m_dac) || dac_valid !== m_pend || sign !== m_sgn ||
          overrun !== m_ovr) begin
        failed++;
        $display("FAIL model c=%0d: got dac=%0h v=%0b s=%0b o=%0b expected dac=%0h v=%0b s=%0b o=%0b",
                 c, DAC, dac_valid, sign, overrun, m_dac, m_pend, m_sgn, m_ovr);
      end
      tests++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
